// File: rtl/sonar_rx_pkg.sv
// Shared types and constants for the sonar frame receiver: parser state codes,
// ASCII symbols of the "aaa,ddd#" frame and the 7E2 character format.
package sonar_rx_pkg;

   typedef enum logic [3:0] {
      Espera = 4'd0,
      Ang1   = 4'd1,
      Ang2   = 4'd2,
      Virg   = 4'd3,
      Dist0  = 4'd4,
      Dist1  = 4'd5,
      Dist2  = 4'd6,
      Fim    = 4'd7
   } parser_state_e;

   localparam logic [6:0] ASC_0    = 7'h30;
   localparam logic [6:0] ASC_9    = 7'h39;
   localparam logic [6:0] ASC_VIRG = 7'h2C;
   localparam logic [6:0] ASC_FIM  = 7'h23;

   localparam int unsigned DATA_BITS = 7;
   localparam int unsigned STOP_BITS = 2;

   function automatic logic is_digit(input logic [6:0] ch);
      return (ch >= ASC_0) && (ch <= ASC_9);
   endfunction

endpackage

// File: rtl/uart_rx_7e2.sv
// 7E2 asynchronous character receiver: 2-FF synchroniser, mid-bit sampling,
// one-cycle char_valid_o with parity and stop-bit error flags.
module uart_rx_7e2
   import sonar_rx_pkg::*;
#(
   parameter int unsigned BitTicks = 434
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rx_i,
   output logic [6:0] char_o,
   output logic       char_valid_o,
   output logic       par_err_o,
   output logic       stop_err_o,
   output logic       rx_idle_o
);

   localparam int unsigned HalfTicks = BitTicks / 2;
   localparam int unsigned CntW      = $clog2(BitTicks + 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop1, StStop2} rx_state_e;

   rx_state_e       state_q;
   logic [1:0]      sync_q;
   logic            prev_q;
   logic [CntW-1:0] cnt_q;
   logic [2:0]      bit_q;
   logic [6:0]      data_q;
   logic            par_q;
   logic            stop1_q;

   logic line, fall, bit_done, half_done;

   assign line      = sync_q[1];
   assign fall      = prev_q & ~line;
   assign bit_done  = (cnt_q == CntW'(BitTicks - 1));
   assign half_done = (cnt_q == CntW'(HalfTicks - 1));
   assign rx_idle_o = (state_q == StIdle);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         sync_q       <= 2'b11;
         prev_q       <= 1'b1;
         cnt_q        <= '0;
         bit_q        <= '0;
         data_q       <= '0;
         par_q        <= 1'b0;
         stop1_q      <= 1'b0;
         char_o       <= '0;
         char_valid_o <= 1'b0;
         par_err_o    <= 1'b0;
         stop_err_o   <= 1'b0;
      end else begin
         sync_q       <= {sync_q[0], rx_i};
         prev_q       <= line;
         char_valid_o <= 1'b0;
         case (state_q)
            StIdle: begin
               cnt_q <= '0;
               if (fall) state_q <= StStart;
            end
            StStart: begin
               if (half_done) begin
                  // A line already back high at mid start bit was only a glitch.
                  cnt_q   <= '0;
                  bit_q   <= '0;
                  state_q <= line ? StIdle : StData;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StData: begin
               if (bit_done) begin
                  cnt_q  <= '0;
                  data_q <= {line, data_q[6:1]};
                  bit_q  <= bit_q + 1'b1;
                  if (bit_q == 3'(DATA_BITS - 1)) state_q <= StParity;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StParity: begin
               if (bit_done) begin
                  cnt_q   <= '0;
                  par_q   <= line;
                  state_q <= StStop1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StStop1: begin
               if (bit_done) begin
                  cnt_q   <= '0;
                  stop1_q <= line;
                  state_q <= StStop2;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StStop2: begin
               if (bit_done) begin
                  cnt_q        <= '0;
                  char_o       <= data_q;
                  char_valid_o <= 1'b1;
                  par_err_o    <= (^data_q) ^ par_q;
                  stop_err_o   <= ~(stop1_q & line);
                  state_q      <= StIdle;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: rtl/sonar_frame_rx.sv
// Sonar frame receiver: parses "aaa,ddd#" from the 7E2 line into BCD angle and
// distance, with pronto on a good frame and erro on a discarded one.
module sonar_frame_rx
   import sonar_rx_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned BAUD     = 115200,
   parameter int unsigned GAP_BITS = 20
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        entrada_serial,
   output logic [11:0] angulo,
   output logic [11:0] distancia,
   output logic        pronto,
   output logic        erro,
   output logic [3:0]  db_estado
);

   localparam int unsigned BitTicks = CLK_FREQ / BAUD;
   localparam int unsigned GapTicks = GAP_BITS * BitTicks;
   localparam int unsigned GapW     = $clog2(GapTicks + 1);

   logic [6:0] rx_char;
   logic       rx_valid, rx_par_err, rx_stop_err, rx_idle;

   uart_rx_7e2 #(
      .BitTicks (BitTicks)
   ) u_rx (
      .clk_i        (clock),
      .rst_ni       (reset),
      .rx_i         (entrada_serial),
      .char_o       (rx_char),
      .char_valid_o (rx_valid),
      .par_err_o    (rx_par_err),
      .stop_err_o   (rx_stop_err),
      .rx_idle_o    (rx_idle)
   );

   parser_state_e   state_q;
   logic [11:0]     ang_sh_q, dist_sh_q;
   logic [GapW-1:0] gap_q;
   logic            class_ok, char_bad;

   assign db_estado = state_q;
   assign char_bad  = rx_par_err | rx_stop_err;

   always_comb begin
      class_ok = is_digit(rx_char);
      case (state_q)
         Virg:    class_ok = (rx_char == ASC_VIRG);
         Fim:     class_ok = (rx_char == ASC_FIM);
         default: class_ok = is_digit(rx_char);
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= Espera;
         ang_sh_q  <= '0;
         dist_sh_q <= '0;
         gap_q     <= '0;
         angulo    <= '0;
         distancia <= '0;
         pronto    <= 1'b0;
         erro      <= 1'b0;
      end else begin
         pronto <= 1'b0;
         erro   <= 1'b0;
         if (rx_valid) begin
            gap_q <= '0;
            if (state_q == Espera) begin
               // Noise and stray separators between frames are dropped silently.
               if (!char_bad && class_ok) begin
                  ang_sh_q[11:8] <= rx_char[3:0];
                  state_q        <= Ang1;
               end
            end else if (char_bad || !class_ok) begin
               erro      <= 1'b1;
               state_q   <= Espera;
               ang_sh_q  <= '0;
               dist_sh_q <= '0;
            end else begin
               case (state_q)
                  Ang1: begin ang_sh_q[7:4]   <= rx_char[3:0]; state_q <= Ang2;  end
                  Ang2: begin ang_sh_q[3:0]   <= rx_char[3:0]; state_q <= Virg;  end
                  Virg: state_q <= Dist0;
                  Dist0: begin dist_sh_q[11:8] <= rx_char[3:0]; state_q <= Dist1; end
                  Dist1: begin dist_sh_q[7:4]  <= rx_char[3:0]; state_q <= Dist2; end
                  Dist2: begin dist_sh_q[3:0]  <= rx_char[3:0]; state_q <= Fim;   end
                  Fim: begin
                     angulo    <= ang_sh_q;
                     distancia <= dist_sh_q;
                     pronto    <= 1'b1;
                     state_q   <= Espera;
                  end
                  default: state_q <= Espera;
               endcase
            end
         end else if (state_q != Espera && rx_idle) begin
            if (gap_q == GapW'(GapTicks - 1)) begin
               erro      <= 1'b1;
               state_q   <= Espera;
               gap_q     <= '0;
               ang_sh_q  <= '0;
               dist_sh_q <= '0;
            end else begin
               gap_q <= gap_q + 1'b1;
            end
         end else begin
            gap_q <= '0;
         end
      end
   end

endmodule

// File: tb/tb_sonar_frame_rx.sv
// Self-checking bench for sonar_frame_rx: table of frames plus hand-written
// gap-timeout and mid-frame reset sequences.
module tb_sonar_frame_rx;

   localparam int BIT  = 48;
   localparam int HALF = BIT / 2;
   localparam int GAP  = 20 * BIT;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        entrada_serial = 1'b1;
   logic [11:0] angulo, distancia;
   logic        pronto, erro;
   logic [3:0]  db_estado;

   sonar_frame_rx #(
      .CLK_FREQ (4_800_000),
      .BAUD     (100_000),
      .GAP_BITS (20)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .entrada_serial (entrada_serial),
      .angulo         (angulo),
      .distancia      (distancia),
      .pronto         (pronto),
      .erro           (erro),
      .db_estado      (db_estado)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_checks = 0, n_errors = 0;
   int n_pronto = 0, n_erro = 0, last_pronto_cyc = 0, last_erro_cyc = 0, viol = 0;
   int t_end = 0;
   logic prev_p = 1'b0, prev_e = 1'b0;

   always @(negedge clock) begin
      if (pronto) begin n_pronto++; last_pronto_cyc = cyc; end
      if (erro)   begin n_erro++;   last_erro_cyc   = cyc; end
      if ((pronto && erro) || (pronto && prev_p) || (erro && prev_e)) viol++;
      prev_p = pronto;
      prev_e = erro;
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic bit_out(input logic v);
      entrada_serial = v;
      repeat (BIT) @(posedge clock);
      #1;
   endtask

   task automatic send_char(input logic [6:0] ch, input logic flip);
      bit_out(1'b0);
      for (int b = 0; b < 7; b++) bit_out(ch[b]);
      bit_out((^ch) ^ flip);
      bit_out(1'b1);
      bit_out(1'b1);
      t_end = cyc;
   endtask

   task automatic send_str(input logic [63:0] text, input int len, input int flip_idx);
      logic [7:0] c;
      for (int j = 0; j < len; j++) begin
         c = text[8*(len-1-j) +: 8];
         send_char(c[6:0], j == flip_idx);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   typedef struct {
      logic [63:0] text;
      int          len;
      int          flip_idx;
      int          glitch;
      int          exp_pronto;
      int          exp_erro;
      logic [11:0] exp_ang;
      logic [11:0] exp_dist;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int p0, e0, diff;
      vecs[0] = '{"090,123#", 8, -1, 0, 1, 0, 12'h090, 12'h123};
      // Parity error on '1'; trailing "0#" then starts and breaks a new frame.
      vecs[1] = '{"045,010#", 8,  5, 0, 0, 2, 12'h090, 12'h123};
      vecs[2] = '{"180,300#", 8, -1, 0, 1, 0, 12'h180, 12'h300};
      vecs[3] = '{"12a,...#", 8, -1, 0, 0, 1, 12'h180, 12'h300};
      vecs[4] = '{"##,#",     4, -1, 1, 0, 0, 12'h180, 12'h300};
      vecs[5] = '{"999,000#", 8, -1, 0, 1, 0, 12'h999, 12'h000};

      idle(5);
      check("reset_angulo", angulo, 0);
      check("reset_distancia", distancia, 0);
      check("reset_pronto", pronto, 0);
      check("reset_erro", erro, 0);
      check("reset_estado", db_estado, 0);
      reset = 1'b1;
      idle(2 * BIT);

      for (int i = 0; i < 6; i++) begin
         p0 = n_pronto;
         e0 = n_erro;
         if (vecs[i].glitch != 0) begin
            entrada_serial = 1'b0;
            idle(HALF / 2);
            entrada_serial = 1'b1;
            idle(2 * BIT);
            check($sformatf("v%0d_glitch_estado", i), db_estado, 0);
         end
         send_str(vecs[i].text, vecs[i].len, vecs[i].flip_idx);
         idle(4 * BIT);
         check($sformatf("v%0d_pronto_count", i), n_pronto - p0, vecs[i].exp_pronto);
         check($sformatf("v%0d_erro_count", i), n_erro - e0, vecs[i].exp_erro);
         check($sformatf("v%0d_angulo", i), angulo, vecs[i].exp_ang);
         check($sformatf("v%0d_distancia", i), distancia, vecs[i].exp_dist);
         check($sformatf("v%0d_estado", i), db_estado, 0);
         if (vecs[i].exp_pronto != 0) begin
            diff = last_pronto_cyc - t_end;
            check($sformatf("v%0d_pronto_latency_ok(diff=%0d)", i, diff),
                  int'(diff >= -HALF && diff <= -HALF + 8), 1);
         end
      end

      // Gap timeout after a partial frame.
      p0 = n_pronto;
      e0 = n_erro;
      send_str("090", 3, -1);
      check("gap_estado_virg", db_estado, 3);
      idle(21 * BIT);
      check("gap_erro_count", n_erro - e0, 1);
      diff = last_erro_cyc - t_end;
      check($sformatf("gap_latency_ok(diff=%0d)", diff),
            int'(diff >= GAP - HALF && diff <= GAP - HALF + 8), 1);
      check("gap_estado", db_estado, 0);
      check("gap_angulo_kept", angulo, 12'h999);
      send_str("001,002#", 8, -1);
      idle(4 * BIT);
      check("gap_next_pronto", n_pronto - p0, 1);
      check("gap_next_angulo", angulo, 12'h001);
      check("gap_next_distancia", distancia, 12'h002);

      // Reset in the middle of the distance tens character.
      send_str("170,2", 5, -1);
      check("rst_estado_dist1", db_estado, 5);
      bit_out(1'b0);
      bit_out(1'b1);
      entrada_serial = 1'b0;
      idle(BIT / 2);
      reset = 1'b0;
      #1;
      check("rst_angulo", angulo, 0);
      check("rst_distancia", distancia, 0);
      check("rst_estado", db_estado, 0);
      check("rst_pronto", pronto, 0);
      check("rst_erro", erro, 0);
      idle(4);
      entrada_serial = 1'b1;
      idle(4);
      reset = 1'b1;
      idle(2 * BIT);
      p0 = n_pronto;
      e0 = n_erro;
      send_str("170,250#", 8, -1);
      idle(4 * BIT);
      check("rst_next_pronto", n_pronto - p0, 1);
      check("rst_next_erro", n_erro - e0, 0);
      check("rst_next_angulo", angulo, 12'h170);
      check("rst_next_distancia", distancia, 12'h250);

      check("pulse_rules_violations", viol, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sonar_frame_rx.md
Name: sonar_frame_rx

Overview:
Receive-side counterpart of the sonar serial transmitter. Deserialises the 7E2 asynchronous line and parses the ASCII measurement frame "aaa,ddd#" (3-digit angle, comma, 3-digit distance, terminator). Delivers the angle and distance as BCD with a one-cycle valid pulse. Used on a second board or in loopback benches to consume what the sonar transmits.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz.
BAUD, 115200, line rate. BIT_TICKS = CLK_FREQ/BAUD, integer-truncated (434 at defaults).
GAP_BITS, 20, maximum idle gap between characters inside a frame, in bit-times.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low; clears all state.
entrada_serial  in  1  async serial line, idle high.
angulo  out  12  BCD angle of the last good frame, hundreds in [11:8].
distancia  out  12  BCD distance of the last good frame, hundreds in [11:8].
pronto  out  1  one-cycle pulse: angulo/distancia just updated.
erro  out  1  one-cycle pulse: frame discarded.
db_estado  out  4  parser state code, for the 7-seg debug display.

Behaviour:
- Reset values: angulo=0, distancia=0, pronto=0, erro=0, db_estado=0 (ESPERA). Both FSMs and all counters are cleared.
- Input synchroniser: 2-FF on entrada_serial, reset to 1. All sampling uses the synchronised value.
- Character receiver states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE -> START on a synchronised falling edge.
  - START: wait BIT_TICKS/2 (217 ticks) and resample. If the line is high, treat it as a glitch and return to IDLE with no event.
  - Then sample every BIT_TICKS: 7 data bits LSB first, 1 parity bit, 2 stop bits.
  - After the STOP2 sample, raise an internal char_valid for 1 cycle with the 7-bit char, par_err (XOR of data and parity = 1), and stop_err (either stop sample = 0). Return to IDLE the same cycle.
  - A new start edge is accepted from the next cycle.
- Parser states and codes: ESPERA 0, ANG1 1, ANG2 2, VIRG 3, DIST0 4, DIST1 5, DIST2 6, FIM 7.
  - Digit = 7'h30..7'h39; the stored nibble is char[3:0].
  - ESPERA: a digit goes to ANG1 and stores the angle hundreds. '#', ',' and other characters are ignored silently, with no erro pulse.
  - ANG1 -> ANG2 -> VIRG take the angle tens and units digits.
  - VIRG requires ','.
  - DIST0..DIST2 take the three distance digits.
  - FIM requires '#'.
  - Digits are held in shadow registers. On the '#' in FIM, copy the shadows to angulo/distancia and pulse pronto on the cycle after char_valid. Return to ESPERA.
- Error handling, from any state other than ESPERA:
  - Triggers: a wrong character class, par_err, or stop_err.
  - Response: one-cycle erro pulse, go to ESPERA, shadow registers discarded, outputs unchanged. The offending character is not reinterpreted.
  - A char with par_err or stop_err received in ESPERA is dropped with no erro pulse.
- Gap timeout:
  - A counter runs while the parser is outside ESPERA and the receiver is in IDLE. It clears on each start edge.
  - Reaching GAP_BITS*BIT_TICKS gives erro and a return to ESPERA.
- pronto and erro are mutually exclusive and never held for more than 1 cycle.
- Outputs persist until the next good frame or reset.
- Reset asserted mid-character or mid-frame aborts everything immediately. After release, the first character is only recognised on a fresh falling edge.
- No range check on values: "999" is legal.

Decomposition:
- Package sonar_rx_pkg holds:
  - parser state enum with the fixed codes above;
  - ASCII constants ASC_0=7'h30, ASC_9=7'h39, ASC_VIRG=7'h2C, ASC_FIM=7'h23;
  - the 7E2 frame constants (7 data bits, 2 stop bits).
- Sub-module uart_rx_7e2 holds the synchroniser and character receiver FSM. It exports the char, char_valid, par_err and stop_err to the parser in the top.

Test Plan:
1. Send "090,123#" with correct 7E2 framing at 115200 -> single pronto; angulo=12'h090, distancia=12'h123; erro never asserted; pronto 1 cycle after the final STOP2 sample.
2. Send "045,010#" with the parity bit of '1' flipped -> erro pulse on that char; no pronto. A following "180,300#" -> angulo=12'h180, distancia=12'h300.
3. Send "12a,..." ('a' at position 3) -> erro; state returns to 0. Outputs keep the previous values (from scenario 2: 12'h180 / 12'h300).
4. Send "090" then idle 21 bit-times -> erro pulse at 20 bit-times after the last STOP2. Then "001,002#" -> pronto with 12'h001 / 12'h002.
5. Drive a 100-cycle low glitch on the idle line -> no char_valid, no erro, state stays 0. Send "##,#" in ESPERA -> no pulses at all.
6. Assert reset during the distance tens bit of "170,250#" -> all outputs 0 immediately. After release, "170,250#" resent -> pronto, angulo=12'h170, distancia=12'h250.
